// File: rtl/counter_pkg.sv
// Shared types and constants for the counter checker and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package counter_pkg;

    // Checker lock state. IDLE means the history registers hold nothing yet.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } chk_state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Log lines emitted when the optional logging build is enabled.
    localparam string LOG_MISMATCH_FMT = "@%0tns counter mismatch exp %b got %b cnt %0d";
    localparam string LOG_RELOCK_FMT   = "@%0tns counter relocked";

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Latency: count_o reflects an increment one cycle after inc_i is sampled.
// Backpressure: none; increments past all-ones are dropped silently.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr_n_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise step unless already at all-ones.
    always_comb begin
        count_d = count_q;
        if (!clr_n_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register; the clear path is purely synchronous.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/counter_checker.sv
// Passive monitor predicting a counter's next value from its last sampled enable/reset/data; flags and counts mismatches.
// Latency: error, err_count and locked update 1 cycle after the offending sample; expected is combinational from history.
// Backpressure: none, observe-only. Optional logging compiled in with COUNTER_CHECKER_LOG_EN.
module counter_checker
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int LOCK_RUN = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cnt_enable,
    input  logic             cnt_reset,
    input  logic [WIDTH-1:0] cnt_data,
    output logic             locked,
    output logic             error,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] expected
);

    // Wide enough to hold LOCK_RUN itself.
    localparam int RUN_W = $clog2(LOCK_RUN + 1);

    chk_state_t       state_q;
    chk_state_t       state_d;
    logic [WIDTH-1:0] prev_data_q;
    logic             prev_en_q;
    logic             prev_rst_q;
    logic             error_q;

    logic [WIDTH-1:0] expected_w;
    logic             match_w;
    logic             mismatch_w;
    logic             run_done_w;
    logic             run_inc_w;
    logic             run_clr_n_w;
    logic [RUN_W-1:0] run_count_w;

    // Prediction from history: a counter reset wins over enable; wrap is modulo 2^WIDTH.
    always_comb begin
        expected_w = prev_rst_q ? '0 : (prev_data_q + WIDTH'(prev_en_q));
    end

    // Four-state compare so X/Z on the observed bus is treated as a mismatch.
    // History only exists outside IDLE, so nothing is compared there.
    always_comb begin
        match_w    = (cnt_data === expected_w);
        mismatch_w = (state_q != IDLE) && !match_w;
    end

    // This match completes the required clean run when run count + 1 reaches LOCK_RUN.
    always_comb begin
        run_done_w = ((int'(run_count_w) + 1) >= LOCK_RUN);
    end

    // Lock state transitions.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = LOCKED;
            LOCKED:  state_d = mismatch_w ? FAULT : LOCKED;
            FAULT: begin
                if (mismatch_w) begin
                    state_d = FAULT;
                end else if (run_done_w) begin
                    state_d = LOCKED;
                end else begin
                    state_d = FAULT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Run counter only advances on matches while in FAULT; it is held at zero otherwise,
    // and cleared on a mismatch or on the match that completes the relock.
    always_comb begin
        run_inc_w   = (state_q == FAULT) && !mismatch_w;
        run_clr_n_w = reset_n && (state_q == FAULT) && !mismatch_w && !run_done_w;
    end

    // State, history and error pulse. History always re-baselines on the observed bus.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            prev_data_q <= '0;
            prev_en_q   <= 1'b0;
            prev_rst_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_data_q <= cnt_data;
            prev_en_q   <= cnt_enable;
            prev_rst_q  <= cnt_reset;
            error_q     <= mismatch_w;
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk     (clk),
        .clr_n_i (reset_n),
        .inc_i   (mismatch_w),
        .count_o (err_count)
    );

    sat_counter #(
        .W (RUN_W)
    ) u_run_cnt (
        .clk     (clk),
        .clr_n_i (run_clr_n_w),
        .inc_i   (run_inc_w),
        .count_o (run_count_w)
    );

    assign locked   = (state_q == LOCKED);
    assign error    = error_q;
    assign expected = expected_w;

`ifdef COUNTER_CHECKER_LOG_EN
    logic [ERR_W-1:0] log_cnt_w;

    // Count value that becomes visible together with the error pulse being logged.
    always_comb begin
        log_cnt_w = (err_count == {ERR_W{1'b1}}) ? err_count : (err_count + ERR_W'(1));
    end

    // Mismatch and relock log lines, emitted at the edge that commits them.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (mismatch_w) begin
                $display("%s", $sformatf(LOG_MISMATCH_FMT, $time, expected_w, cnt_data, log_cnt_w));
            end
            if ((state_q == FAULT) && (state_d == LOCKED)) begin
                $display("%s", $sformatf(LOG_RELOCK_FMT, $time));
            end
        end
    end
`endif

endmodule

// File: tb/tb_counter_checker.sv
module tb_counter_checker;

    localparam int W    = 4;
    localparam int LR   = 3;
    localparam int EW   = 4;
    localparam int EMAX = (1 << EW) - 1;
    localparam int DMOD = 1 << W;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cnt_enable;
    logic          cnt_reset;
    logic [W-1:0]  cnt_data;
    logic          locked;
    logic          error;
    logic [EW-1:0] err_count;
    logic [W-1:0]  expected;

    always #5 clk = ~clk;

    counter_checker #(
        .WIDTH    (W),
        .LOCK_RUN (LR),
        .ERR_W    (EW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cnt_enable (cnt_enable),
        .cnt_reset  (cnt_reset),
        .cnt_data   (cnt_data),
        .locked     (locked),
        .error      (error),
        .err_count  (err_count),
        .expected   (expected)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d @%0t", name, got, want, $time);
        end
    endtask

    // Reference model: remembers the last observed sample, totals every mismatch
    // without bound, and counts clean predictions since the last mismatch.
    bit m_hv;
    int m_pd;
    bit m_pen;
    bit m_prst;
    int m_total;
    bit m_seen;
    int m_streak;
    bit m_err;

    function automatic int m_expected();
        if (!m_hv || m_prst) return 0;
        return (m_pd + int'(m_pen)) % DMOD;
    endfunction

    function automatic bit m_locked();
        return m_hv && (!m_seen || (m_streak >= LR));
    endfunction

    function automatic int m_count();
        return (m_total > EMAX) ? EMAX : m_total;
    endfunction

    task automatic model_step(input bit rn, input bit en, input bit rs, input logic [W-1:0] d);
        if (!rn) begin
            m_hv = 0; m_pd = 0; m_pen = 0; m_prst = 0;
            m_total = 0; m_seen = 0; m_streak = 0; m_err = 0;
        end else begin
            if (m_hv) begin
                m_err = (int'(d) != m_expected());
                if (m_err) begin
                    m_total++;
                    m_seen   = 1;
                    m_streak = 0;
                end else begin
                    m_streak++;
                end
            end else begin
                m_err = 0;
            end
            m_pd   = int'(d);
            m_pen  = en;
            m_prst = rs;
            m_hv   = 1;
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("locked", 32'(locked), 32'(m_locked()));
            chk("error", 32'(error), 32'(m_err));
            chk("err_count", 32'(err_count), 32'(m_count()));
            chk("expected", 32'(expected), 32'(m_expected()));
        end
    end

    // One sample: inputs set away from the edge, model advanced at the edge,
    // return at the following negedge with outputs settled.
    task automatic drive(input bit rn, input bit en, input bit rs, input logic [W-1:0] d);
        reset_n    = rn;
        cnt_enable = en;
        cnt_reset  = rs;
        cnt_data   = d;
        @(posedge clk);
        model_step(rn, en, rs, d);
        @(negedge clk);
    endtask

    // Value a well-behaved counter is currently showing.
    logic [W-1:0] c;

    task automatic tick(input bit en, input bit rs);
        drive(1'b1, en, rs, c);
        c = rs ? '0 : (c + W'(en));
    endtask

    initial begin
        reset_n = 1'b0; cnt_enable = 1'b0; cnt_reset = 1'b0; cnt_data = '0;
        m_hv = 0; m_pd = 0; m_pen = 0; m_prst = 0;
        m_total = 0; m_seen = 0; m_streak = 0; m_err = 0;
        @(negedge clk);

        // Reset state
        drive(1'b0, 1'b0, 1'b0, '0);
        cmp_en = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_expected", 32'(expected), 0);

        // Clean run with wrap
        c = '0;
        tick(1'b0, 1'b1);
        chk("first_sample_locked", 32'(locked), 1);
        chk("first_sample_error", 32'(error), 0);
        repeat (4) tick(1'b0, 1'b1);
        repeat (20) tick(1'b1, 1'b0);
        chk("clean_err_count", 32'(err_count), 0);
        chk("clean_locked", 32'(locked), 1);
        chk("clean_expected", 32'(expected), 4);

        // Single glitch then relock after LOCK_RUN clean samples
        for (int i = 0; i < 32 && c != 4'd6; i++) tick(1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 4'd9);
        c = 4'd10;
        chk("glitch_error", 32'(error), 1);
        chk("glitch_err_count", 32'(err_count), 1);
        chk("glitch_locked", 32'(locked), 0);
        repeat (2) tick(1'b1, 1'b0);
        chk("glitch_run2_locked", 32'(locked), 0);
        tick(1'b1, 1'b0);
        chk("glitch_relocked", 32'(locked), 1);
        chk("glitch_error_clear", 32'(error), 0);

        // Reset and enable together: reset wins
        for (int i = 0; i < 32 && c != 4'd7; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        chk("rst_en_expected", 32'(expected), 0);
        tick(1'b1, 1'b0);
        chk("rst_en_read0_error", 32'(error), 0);
        drive(1'b1, 1'b1, 1'b1, c);
        drive(1'b1, 1'b1, 1'b0, 4'd8);
        chk("rst_en_read8_error", 32'(error), 1);
        chk("rst_en_err_count", 32'(err_count), 2);
        c = 4'd9;
        repeat (3) tick(1'b1, 1'b0);
        chk("rst_en_relocked", 32'(locked), 1);

        // Stuck data with enable high
        for (int i = 0; i < 32 && c != 4'd4; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 1'b0, 4'd4);
            chk("stuck_error", 32'(error), 1);
            chk("stuck_locked", 32'(locked), 0);
        end
        chk("stuck_err_count", 32'(err_count), 7);
        c = 4'd5;
        repeat (3) tick(1'b1, 1'b0);
        chk("stuck_relocked", 32'(locked), 1);

        // Saturation: 10 more mismatches from 7 cap at 15
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 1'b1, 1'b0, 4'd4);
            chk("sat_error", 32'(error), 1);
            chk("sat_err_count", 32'(err_count), 32'((7 + k > 15) ? 15 : 7 + k));
        end

        // Checker reset mid-FAULT
        drive(1'b0, 1'b1, 1'b0, 4'd4);
        chk("midrst_locked", 32'(locked), 0);
        chk("midrst_error", 32'(error), 0);
        chk("midrst_err_count", 32'(err_count), 0);
        chk("midrst_expected", 32'(expected), 0);
        c = 4'd3;
        tick(1'b1, 1'b0);
        chk("midrst_rebase_error", 32'(error), 0);
        chk("midrst_rebase_locked", 32'(locked), 1);
        chk("midrst_rebase_expected", 32'(expected), 4);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                drive(1'b0, 1'($urandom), 1'($urandom), W'($urandom));
                c = W'($urandom);
            end else if (r < 10) begin
                logic [W-1:0] g;
                bit ge, gr;
                g  = W'($urandom);
                ge = 1'($urandom);
                gr = ($urandom_range(0, 7) == 0);
                drive(1'b1, ge, gr, g);
                c = gr ? '0 : (g + W'(ge));
            end else begin
                tick(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
            end
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Passive observer at the far end of the counter interface (clk, enable, reset, data).
- Every cycle it predicts the counter's next data value from the previously sampled enable, reset and data. It flags mismatches, counts them, and reports lock status.
- Sits beside any counter instance in testbenches or in-system monitoring. It drives nothing back into the counter.

Parameters:
- WIDTH, 4, width of observed data bus.
- LOCK_RUN, 3, consecutive correct predictions needed to return to lock after a fault (≥1).
- ERR_W, 8, width of the saturating mismatch counter.

Ports:
- clk  in  1  clock; all sampling on posedge.
- reset_n  in  1  checker reset; synchronous, active-low.
- cnt_enable  in  1  observed counter enable.
- cnt_reset  in  1  observed counter reset (active-high, synchronous at the counter).
- cnt_data  in  WIDTH  observed counter output.
- locked  out  1  high while state is LOCKED.
- error  out  1  one-cycle pulse per detected mismatch.
- err_count  out  ERR_W  total mismatches since reset; saturates at all-ones.
- expected  out  WIDTH  current prediction being compared against cnt_data.

Behaviour:
- Reset (reset_n=0 at posedge):
  - state=IDLE, history invalid.
  - locked=0, error=0, err_count=0, expected=0.
  - Reset asserted mid-operation discards all history immediately.
- History registers: prev_data, prev_en and prev_rst are updated every non-reset cycle from the cnt_* inputs.
- Prediction (combinational from history):
  - expected = prev_rst ? 0 : prev_data + prev_en, modulo 2^WIDTH.
  - Wrap is legal: all-ones plus enable predicts 0.
- Compare: match = (cnt_data == expected), evaluated only when history is valid.
- States:
  - IDLE: first non-reset sample loads history only; no compare. Next state is LOCKED.
  - LOCKED:
    - match → stay in LOCKED.
    - mismatch → error=1 next cycle, err_count+1, state FAULT, run=0.
  - FAULT:
    - match → run+1; when run reaches LOCK_RUN, go to LOCKED.
    - mismatch → error pulse, err_count+1, run=0.
- History update after a mismatch: history always loads the actual cnt_data, never the prediction. This re-baselines on the observed value.
- Latency: error and the count increment appear 1 cycle after the mismatching sample. locked falls in that same cycle.
- Back-to-back mismatches give error high on consecutive cycles, one count each.
- err_count holds at 2^ERR_W−1 once it saturates, while error keeps pulsing.
- cnt_reset and cnt_enable high together: reset wins, so the prediction is 0.
- X/Z on cnt_data counts as a mismatch (use a 4-state compare in simulation).

Optional Feature:
- Macro: COUNTER_CHECKER_LOG_EN.
- Defined: on every error pulse, print "@<time>ns counter mismatch exp <bin> got <bin> cnt <dec>". On each FAULT→LOCKED transition, print "@<time>ns counter relocked".
- Undefined: no display code is compiled; RTL behaviour is identical.

Decomposition:
- Package counter_pkg holds:
  - typedef enum logic [1:0] {IDLE, LOCKED, FAULT} chk_state_t;
  - localparam DEFAULT_WIDTH=4;
  - the log format string constant.
- Sub-module sat_counter (parameter W): synchronous active-low clear, increment input, saturating count. Used once for err_count and once for the lock run counter.

Test Plan:
1. Clean run: counter reset 5 cycles, then enable for 20 cycles (data 0→15→0→3) → locked=1 from cycle 2 onward, wrap 15→0 accepted, error never asserts, err_count=0.
2. Single glitch: force cnt_data=9 for one cycle where 6 is expected → error pulses once the next cycle, err_count=1, locked=0. After LOCK_RUN=3 correct cycles, locked=1.
3. Simultaneous cnt_reset=1 and cnt_enable=1 with data=7 → expected=0 next cycle; counter reading 0 gives no error, reading 8 gives an error.
4. Stuck data: hold cnt_data=4 with enable=1 for 5 cycles → error high on 5 consecutive cycles, err_count=5, locked stays 0.
5. Saturation with ERR_W=2: inject 6 mismatches → err_count stops at 3, error still pulses 6 times.
6. Checker reset mid-FAULT: reset_n=0 for 1 cycle with err_count=2 → all outputs 0. The next sample only re-baselines (no error), and locked=1 the following cycle.
